// File: rtl/barrel_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package barrel_shifter_pkg;

    // Shift operation carried with every beat through the pipeline.
    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_mode_e;

    localparam int MODE_W = 2;

    // Fixed shift distance handled by pipeline stage k: the first stage
    // takes the largest power of two, the last stage takes distance 1.
    function automatic int stage_dist(input int shw, input int k);
        return 32'sd1 << (shw - 32'sd1 - k);
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_chk.sv
// Protocol checker for barrel_shifter_pipe: result stability under
// backpressure and the combinational ready relation.
module barrel_shifter_pipe_chk #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data
);

    // A held result must stay valid and unchanged until it is taken.
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    // Input side is ready exactly when the output is not stalled.
    a_in_ready: assert property (@(posedge clk) disable iff (rst)
        in_ready == !(out_valid && !out_ready));

endmodule

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One combinational stage of the barrel shifter: conditionally shifts the
// operand by a fixed distance DIST in the beat's own mode and fill bit.
module shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_mode_e      mode_i,
    input  logic             fill_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    // Apply the fixed-distance shift only when this stage's amount bit is set.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (mode_i)
                SLL:     data_o = {data_i[WIDTH-DIST-1:0], {DIST{fill_i}}};
                SRL:     data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
                SRA:     data_o = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
                ROL:     data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                default: data_o = data_i;
            endcase
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Fully pipelined barrel shifter with valid/ready handshake on both sides.
// An input register captures the beat, SHW shift stages follow, and the
// final register drives Out/OutValid. A single global stall freezes the
// whole pipeline so timing stays deterministic under backpressure.
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   ShiftAmount,
    input  logic [1:0]       Mode,
    input  logic             ShiftIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out
);

    // Everything a beat needs to finish its shift travels with it, so
    // back-to-back beats of different modes never see each other's controls.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        shift_mode_e      mode;
        logic             fill;
    } stage_t;

    stage_t           stage_q [SHW];
    stage_t           stage_d [SHW];
    logic [WIDTH-1:0] shifted_s [SHW];
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             stall_s;

    // Global stall: a result is waiting and the consumer is not taking it.
    always_comb begin
        stall_s = out_valid_q & ~OutReady;
        InReady = ~stall_s;
    end

    // Stage k consumes amount bit SHW-1-k with distance 2^(SHW-1-k).
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (stage_dist(SHW, k))
        ) u_stage (
            .data_i (stage_q[k].data),
            .mode_i (stage_q[k].mode),
            .fill_i (stage_q[k].fill),
            .en_i   (stage_q[k].shamt[SHW-1-k]),
            .data_o (shifted_s[k])
        );
    end

    // Next-state for the input register: capture a beat or insert a bubble.
    // Bubble payload is forced to zero so undriven inputs never enter the pipe.
    always_comb begin
        stage_d[0] = stage_q[0];
        if (stall_s) begin
            stage_d[0] = stage_q[0];
        end else if (InValid) begin
            stage_d[0].valid = 1'b1;
            stage_d[0].data  = In;
            stage_d[0].shamt = ShiftAmount;
            stage_d[0].mode  = shift_mode_e'(Mode);
            stage_d[0].fill  = ShiftIn;
        end else begin
            stage_d[0].valid = 1'b0;
            stage_d[0].data  = {WIDTH{1'b0}};
            stage_d[0].shamt = {SHW{1'b0}};
            stage_d[0].mode  = SLL;
            stage_d[0].fill  = 1'b0;
        end
    end

    // Next-state for the inner stage registers: advance shifted beats or hold.
    always_comb begin
        for (int k = 1; k < SHW; k++) begin
            stage_d[k] = stage_q[k];
            if (stall_s) begin
                stage_d[k] = stage_q[k];
            end else begin
                stage_d[k]      = stage_q[k-1];
                stage_d[k].data = shifted_s[k-1];
            end
        end
    end

    // Next-state for the output register fed by the last shift stage.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (stall_s) begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = stage_q[SHW-1].valid;
            out_data_d  = shifted_s[SHW-1];
        end
    end

    // Pipeline registers; reset drops every beat in flight and wins over stall.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
        end else begin
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= stage_d[k];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign OutValid = out_valid_q;
    assign Out      = out_data_q;

endmodule
